// File: rtl/cpu_pkg.sv
// Shared constants for the DL register bank: default data width, buffer
// depth and channel count, plus the index of each output bus channel.
package cpu_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int DEPTH_DEF = 4;
    localparam int NBUS_DEF  = 3;

    // Output bus channel indices into BUS_ENABLE / BUS_OUT.
    localparam int BUS_DB  = 0;
    localparam int BUS_ADL = 1;
    localparam int BUS_ADH = 2;

    // Occupancy counter width: enough to hold 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/dl_fifo.sv
// Circular buffer behind the DL register bank: storage, read/write
// pointers, occupancy count and the sticky overflow/underflow flags.
// DEPTH must be a power of two so the pointers wrap by natural rollover.
module dl_fifo
    import cpu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     load_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic                     overflow_o,
    output logic                     underflow_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             ovf_q,    ovf_d;
    logic             udf_q,    udf_d;

    logic empty;
    logic full;
    logic do_pop;
    logic do_push;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

    // A pop on a non-empty buffer always happens; a push happens when there
    // is room, or when the same-cycle pop frees a slot (pop-then-push).
    assign do_pop  = pop_i && !empty;
    assign do_push = load_i && (!full || do_pop);

    // Next-state for pointers, occupancy and the sticky error flags.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;

        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);

        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // A load into a full buffer is dropped unless a pop makes room.
        if (load_i && full && !pop_i) ovf_d = 1'b1;
        // A pop of an empty buffer is ignored, whether or not a load accompanies it.
        if (pop_i && empty)           udf_d = 1'b1;
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Entry storage; written at the write pointer on an accepted push.
    always_ff @(posedge clk_i) begin
        // NOTE: the storage array is deliberately not reset; entries are only
        // visible through the pointers, which are reset, so stale data is unreachable.
        if (rst_ni && do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign head_o      = empty ? '0 : mem_q[rd_ptr_q];
    assign count_o     = count_q;
    assign full_o      = full;
    assign empty_o     = empty;
    assign overflow_o  = ovf_q;
    assign underflow_o = udf_q;

endmodule

// File: rtl/reg_dl_bank.sv
// DL register bank: a small FIFO whose head can be copied into any of NBUS
// registered output channels (DB, ADL, ADH by default).
// Optional feature macro: REG_DL_BANK_BYPASS_EN -- when defined, a channel
// enabled while the buffer is empty captures the incoming DATA directly in
// the same cycle as it is pushed.
module reg_dl_bank
    import cpu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int NBUS  = NBUS_DEF
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     LOAD,
    input  logic [WIDTH-1:0]         DATA,
    input  logic                     POP,
    input  logic [NBUS-1:0]          BUS_ENABLE,
    output logic [NBUS*WIDTH-1:0]    BUS_OUT,
    output logic [WIDTH-1:0]         HEAD,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic                     FULL,
    output logic                     EMPTY,
    output logic                     OVERFLOW,
    output logic                     UNDERFLOW
);

    logic [NBUS*WIDTH-1:0] bus_q, bus_d;
    logic [WIDTH-1:0]      head;
    logic                  empty;

    dl_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (CLK),
        .rst_ni      (RST_N),
        .load_i      (LOAD),
        .data_i      (DATA),
        .pop_i       (POP),
        .head_o      (head),
        .count_o     (COUNT),
        .full_o      (FULL),
        .empty_o     (empty),
        .overflow_o  (OVERFLOW),
        .underflow_o (UNDERFLOW)
    );

    // Channel next-state: enabled channels take the pre-edge head, so a
    // same-cycle pop still delivers the entry being discarded.
    always_comb begin
        bus_d = bus_q;
        for (int i = 0; i < NBUS; i++) begin
            if (BUS_ENABLE[i]) begin
                if (!empty) begin
                    bus_d[i*WIDTH +: WIDTH] = head;
                end
`ifdef REG_DL_BANK_BYPASS_EN
                else if (LOAD) begin
                    bus_d[i*WIDTH +: WIDTH] = DATA;
                end
`endif
            end
        end
    end

    // Channel output registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            bus_q <= '0;
        end else begin
            bus_q <= bus_d;
        end
    end

    assign BUS_OUT = bus_q;
    assign HEAD    = head;
    assign EMPTY   = empty;

endmodule

// File: doc/reg_dl_bank.md
REG_DL_BANK -- requirements
Module: reg_dl_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, buffer entries; power of two, >=2.
REQ-003 SHALL have parameter NBUS, default 3, output bus channels (0=DB, 1=ADL, 2=ADH).
REQ-004 CLK  input  1  sole clock; all state updates on rising edge.
REQ-005 RST_N  input  1  reset, synchronous, active-low.
REQ-006 LOAD  input  1  push DATA into the buffer.
REQ-007 DATA  input  WIDTH  value to latch.
REQ-008 POP  input  1  discard head entry.
REQ-009 BUS_ENABLE  input  NBUS  per-channel request to copy head to that channel's output register.
REQ-010 BUS_OUT  output  NBUS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]; registered.
REQ-011 HEAD  output  WIDTH  current head entry; 0 when empty.
REQ-012 COUNT  output  clog2(DEPTH)+1  occupied entries.
REQ-013 FULL, EMPTY  output  1 each  COUNT==DEPTH, COUNT==0.
REQ-014 OVERFLOW, UNDERFLOW  output  1 each  sticky error flags.

Function
REQ-015 SHALL store entries in FIFO order; read and write pointers wrap modulo DEPTH.
REQ-016 LOAD with FULL=0 SHALL write DATA at write pointer; COUNT+1 next cycle.
REQ-017 LOAD with FULL=1 and POP=0 SHALL drop DATA, leave contents unchanged, set OVERFLOW.
REQ-018 POP with EMPTY=0 SHALL advance read pointer; COUNT-1 next cycle.
REQ-019 POP with EMPTY=1 SHALL be ignored and set UNDERFLOW.
REQ-020 LOAD and POP together with EMPTY=0 (including FULL=1) SHALL pop then push; COUNT unchanged; no flag set.
REQ-021 LOAD and POP together with EMPTY=1 SHALL push only and set UNDERFLOW.
REQ-022 BUS_ENABLE[i]=1 with EMPTY=0 SHALL load channel i register with pre-edge HEAD; one-cycle latency.
REQ-023 BUS_ENABLE[i]=0, or EMPTY=1 without bypass, SHALL hold channel i value indefinitely.
REQ-024 Multiple BUS_ENABLE bits SHALL load all selected channels with the same HEAD in one cycle.
REQ-025 BUS_ENABLE and POP in the same cycle SHALL deliver the pre-pop HEAD.
REQ-026 OVERFLOW and UNDERFLOW SHALL remain set until reset.

Reset
REQ-027 RST_N=0 at a rising edge SHALL clear pointers, COUNT, all BUS_OUT channels, OVERFLOW and UNDERFLOW to 0; EMPTY=1, FULL=0, HEAD=0.
REQ-028 Reset SHALL take priority over LOAD, POP and BUS_ENABLE in the same cycle; an in-flight push or pop is discarded.

Configuration
REQ-029 Macro REG_DL_BANK_BYPASS_EN defined: LOAD and BUS_ENABLE[i] while EMPTY=1 SHALL load channel i with DATA in that cycle and still push DATA.
REQ-030 Macro undefined: the REQ-029 case SHALL leave channel i unchanged; DATA reaches the bus only by a later BUS_ENABLE.

Structure
REQ-031 Package cpu_pkg SHALL hold the default WIDTH/DEPTH/NBUS constants and the channel index constants BUS_DB=0, BUS_ADL=1, BUS_ADH=2.
REQ-032 Storage, pointers, COUNT and flags SHALL live in one sub-module dl_fifo; reg_dl_bank adds the channel output registers and bypass logic.

Verification
REQ-033 Reset, then LOAD 0xAA; BUS_ENABLE=001 -> DB=AA, ADL=00, ADH=00 after one cycle, held after enable drops.
REQ-034 LOAD AA,BB,CC,DD -> FULL=1, COUNT=4; LOAD EE -> OVERFLOW=1, HEAD=AA; POP x4 -> EMPTY=1; fifth POP -> UNDERFLOW=1.
REQ-035 FULL with HEAD=AA; LOAD 0x11 with POP -> COUNT=4, HEAD=BB; after three more POPs, HEAD=11 (wrap verified).
REQ-036 HEAD=BB; BUS_ENABLE=111 with POP -> all channels =BB, HEAD advances next cycle.
REQ-037 EMPTY; LOAD 0x5A with BUS_ENABLE=100 -> ADH=5A with macro, ADH unchanged without; COUNT=1 both.
REQ-038 COUNT=2 with flags set; RST_N=0 with LOAD asserted -> COUNT=0, BUS_OUT=0, flags=0.
